// File: rtl/modulo_demux_varredura.sv
// Registered 1-to-N demultiplexer with a manual select mode and an auto-scan
// mode that sweeps the channels with a programmable dwell time.
module modulo_demux_varredura #(
  parameter int SEL_W   = 4,
  parameter int N_CH    = 16,
  parameter int DWELL   = 1000,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic [SEL_W-1:0] S,
  input  logic             modo,
  output logic [N_CH-1:0]  Y,
  output logic [SEL_W-1:0] ch,
  output logic             wrap,
  output logic             sel_err
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_V   = (SEL_W + 1)'(N_CH);
  localparam logic [N_CH-1:0]  Y_IDLE   = {N_CH{ACT_LOW}};

  typedef enum logic {
    MANUAL,
    SCAN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s_ok;
  logic [SEL_W-1:0] s_entry;

  assign s_ok    = ({1'b0, S} < N_CH_V);
  assign s_entry = s_ok ? S : '0;

  // One-hot of idx at the active level when en is set, otherwise all inactive.
  function automatic logic [N_CH-1:0] drive(input logic en, input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] raw;
    raw = '0;
    if (en) raw = {{(N_CH-1){1'b0}}, 1'b1} << idx;
    return raw ^ Y_IDLE;
  endfunction

  // Mode-change edges only perform the transition: entering scan loads the
  // start channel, leaving scan clears the counter and blanks Y without
  // advancing, so a dwell expiry on that edge is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MANUAL;
      ch      <= '0;
      cnt     <= '0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
      Y       <= Y_IDLE;
    end else begin
      wrap <= 1'b0;
      case (state)
        MANUAL: begin
          if (modo) begin
            state   <= SCAN;
            ch      <= s_entry;
            cnt     <= '0;
            sel_err <= 1'b0;
            Y       <= drive(E, s_entry);
          end else if (s_ok) begin
            ch      <= S;
            sel_err <= 1'b0;
            Y       <= drive(E, S);
          end else begin
            sel_err <= 1'b1;
            Y       <= Y_IDLE;
          end
        end
        SCAN: begin
          if (!modo) begin
            state <= MANUAL;
            cnt   <= '0;
            Y     <= Y_IDLE;
          end else if (!E) begin
            Y <= Y_IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (ch == CH_LAST) begin
              ch   <= '0;
              wrap <= 1'b1;
              Y    <= drive(1'b1, '0);
            end else begin
              ch <= ch + SEL_W'(1);
              Y  <= drive(1'b1, ch + SEL_W'(1));
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            Y   <= drive(1'b1, ch);
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_demux_varredura.sv
// Directed bench for modulo_demux_varredura: three instances (16ch/DWELL=3,
// 10ch/DWELL=1, 16ch active-low/DWELL=2) share one input stream.
module tb_modulo_demux_varredura;

  logic        clk;
  logic        rst_n;
  logic        e;
  logic [3:0]  s;
  logic        modo;

  logic [15:0] m_y;
  logic [3:0]  m_ch;
  logic        m_wrap, m_err;
  logic [9:0]  n_y;
  logic [3:0]  n_ch;
  logic        n_wrap, n_err;
  logic [15:0] a_y;
  logic [3:0]  a_ch;
  logic        a_wrap, a_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  modulo_demux_varredura #(.SEL_W(4), .N_CH(16), .DWELL(3), .ACT_LOW(1'b0)) u_m (
    .clk(clk), .rst_n(rst_n), .E(e), .S(s), .modo(modo),
    .Y(m_y), .ch(m_ch), .wrap(m_wrap), .sel_err(m_err)
  );

  modulo_demux_varredura #(.SEL_W(4), .N_CH(10), .DWELL(1), .ACT_LOW(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .E(e), .S(s), .modo(modo),
    .Y(n_y), .ch(n_ch), .wrap(n_wrap), .sel_err(n_err)
  );

  modulo_demux_varredura #(.SEL_W(4), .N_CH(16), .DWELL(2), .ACT_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .E(e), .S(s), .modo(modo),
    .Y(a_y), .ch(a_ch), .wrap(a_wrap), .sel_err(a_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge pass and settle before checking.
  task automatic applyStimulus(input logic r, input logic md, input logic en, input logic [3:0] sel);
    rst_n = r;
    modo  = md;
    e     = en;
    s     = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] scan_ch [7];
    logic       scan_wr [7];
    scan_ch = '{4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd0};
    scan_wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; modo = 1'b1; e = 1'b1; s = 4'd0;

    // Reset held two cycles with scan requested
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd5);
    checkOutput("rst_y",       32'(m_y),    32'h0000);
    checkOutput("rst_ch",      32'(m_ch),   32'd0);
    checkOutput("rst_wrap",    32'(m_wrap), 32'd0);
    checkOutput("rst_err",     32'(m_err),  32'd0);
    checkOutput("rst_y_actlo", 32'(a_y),    32'hFFFF);
    checkOutput("rst_y_n10",   32'(n_y),    32'h000);

    // Manual sweep over all select values
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'(i));
      checkOutput("man_y",  32'(m_y),  32'(1) << i);
      checkOutput("man_ch", 32'(m_ch), 32'(i));
    end
    checkOutput("man_wrap",   32'(m_wrap), 32'd0);
    checkOutput("man_y_actlo", 32'(a_y),   32'h7FFF);

    // Out-of-range select on the 10-channel instance; ch holds 9
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd12);
    checkOutput("oor_y",   32'(n_y),   32'h000);
    checkOutput("oor_err", 32'(n_err), 32'd1);
    checkOutput("oor_ch",  32'(n_ch),  32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3);
    checkOutput("inr_y",       32'(n_y),   32'h008);
    checkOutput("inr_err",     32'(n_err), 32'd0);
    checkOutput("inr_ch",      32'(n_ch),  32'd3);
    checkOutput("inr_y_actlo", 32'(a_y),   32'hFFF7);

    // Manual with E=0: all inactive but ch still follows S
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5);
    checkOutput("man_e0_y",  32'(m_y),  32'h0000);
    checkOutput("man_e0_ch", 32'(m_ch), 32'd5);

    // Scan from 14 with DWELL=3
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
      checkOutput("scan_ch",   32'(m_ch),   32'(scan_ch[i]));
      checkOutput("scan_wrap", 32'(m_wrap), 32'(scan_wr[i]));
      if (i == 0) checkOutput("scan_entry_y", 32'(m_y), 32'h4000);
    end
    checkOutput("scan_wrap_y", 32'(m_y),  32'h0001);
    checkOutput("scan_n10_ch", 32'(n_ch), 32'd6);
    checkOutput("scan_al_ch",  32'(a_ch), 32'd1);
    checkOutput("scan_al_y",   32'(a_y),  32'hFFFD);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
    checkOutput("scan_wrap_end", 32'(m_wrap), 32'd0);
    checkOutput("scan_hold_ch",  32'(m_ch),   32'd0);

    // Freeze mid-dwell (count is 1 on channel 0)
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd14);
    checkOutput("frz_y0", 32'(m_y), 32'h0000);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 4'd14);
    checkOutput("frz_y",  32'(m_y),  32'h0000);
    checkOutput("frz_ch", 32'(m_ch), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
    checkOutput("res_ch0", 32'(m_ch), 32'd0);
    checkOutput("res_y0",  32'(m_y),  32'h0001);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
    checkOutput("res_ch1", 32'(m_ch), 32'd1);
    checkOutput("res_y1",  32'(m_y),  32'h0002);

    // Run on to channel 7, then reset mid-scan
    repeat (18) applyStimulus(1'b1, 1'b1, 1'b1, 4'd14);
    checkOutput("pre_rst_ch", 32'(m_ch), 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd14);
    checkOutput("mid_rst_ch",   32'(m_ch),   32'd0);
    checkOutput("mid_rst_y",    32'(m_y),    32'h0000);
    checkOutput("mid_rst_wrap", 32'(m_wrap), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd9);
    checkOutput("post_rst_y",  32'(m_y),  32'h0200);
    checkOutput("post_rst_ch", 32'(m_ch), 32'd9);

    // Leave scan on the very edge the dwell at channel 15 would expire
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15);
    checkOutput("pre_exit_ch", 32'(m_ch), 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd15);
    checkOutput("exit_ch",   32'(m_ch),   32'd15);
    checkOutput("exit_wrap", 32'(m_wrap), 32'd0);
    checkOutput("exit_y",    32'(m_y),    32'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
    checkOutput("exit_man_ch",  32'(m_ch),  32'd4);
    checkOutput("exit_man_y",   32'(m_y),   32'h0010);
    checkOutput("exit_man_err", 32'(m_err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
